// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default limits.
`timescale 1ns/1ps
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;
  localparam int unsigned MIN_SYNC_STAGES        = 2;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous level into the local clock domain and flags its edges.
`timescale 1ns/1ps
module sync_edge_detect
  import clock_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("sync_edge_detect: SYNC_STAGES must be at least 2");
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_in cycles.
`timescale 1ns/1ps
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   sig_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] period_out,
  output logic [COUNT_WIDTH-1:0] high_out,
  output logic                   period_valid,
  output logic                   timeout
);

  localparam logic [COUNT_WIDTH-1:0] TO_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);

  // The counters must reach the timeout value before they could wrap.
  if ((COUNT_WIDTH < 64) && (64'(TIMEOUT_CYCLES) >= (64'd1 << COUNT_WIDTH))) begin : g_bad_timeout
    $error("clock_period_meter: TIMEOUT_CYCLES must be below 2**COUNT_WIDTH");
  end

  meter_state_t           r_state;
  meter_state_t           w_state_next;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_high_cnt;
  logic [COUNT_WIDTH-1:0] r_period;
  logic [COUNT_WIDTH-1:0] r_high;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   w_level;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_expired;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_n),
    .i_sig   (sig_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assert property (@(posedge clk_in) disable iff (!rst_n) !(w_rise && w_fall));

  assign w_expired = (r_cnt == TO_VAL);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    w_state_next = ST_ARM;
        ST_ARM:     if (w_rise) w_state_next = ST_MEASURE;
        ST_MEASURE: if (!w_rise && w_expired) w_state_next = ST_ARM;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // A rise always takes priority over the timeout; disable overrides both.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_high_cnt <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_cnt      <= '0;
        r_high_cnt <= '0;
        r_timeout  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_ARM: begin
            if (w_rise) begin
              r_cnt      <= COUNT_WIDTH'(1);
              r_high_cnt <= COUNT_WIDTH'(1);
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              r_period   <= r_cnt;
              r_high     <= r_high_cnt;
              r_valid    <= 1'b1;
              r_timeout  <= 1'b0;
              r_cnt      <= COUNT_WIDTH'(1);
              r_high_cnt <= COUNT_WIDTH'(1);
            end else if (w_expired) begin
              r_timeout  <= 1'b1;
              r_cnt      <= '0;
              r_high_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + COUNT_WIDTH'(1);
              if (w_level) r_high_cnt <= r_high_cnt + COUNT_WIDTH'(1);
            end
          end
          default: begin
            r_cnt      <= '0;
            r_high_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign period_out   = r_period;
  assign high_out     = r_high;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;

endmodule
